// File: rtl/if_fetch_pkg.sv
// Shared widths, reset polarity and fetch-stage state types for if_fetch.
package if_fetch_pkg;

  localparam logic        RST_ENABLE  = 1'b1;
  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;
  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  typedef enum logic {
    FETCH_BUSY  = 1'b0,
    FETCH_READY = 1'b1
  } fetch_state_e;

  typedef struct packed {
    fetch_state_e           state;
    logic [INST_ADDR_W-1:0] pc;
    logic [1:0]             cnt;
    logic [INST_W-1:0]      inst_buf;
    logic                   waiting;
    logic                   discard;
  } fetch_regs_t;

  localparam fetch_regs_t FETCH_RESET = '{
    state:    FETCH_BUSY,
    pc:       ZERO_WORD,
    cnt:      2'd0,
    inst_buf: ZERO_WORD,
    waiting:  1'b0,
    discard:  1'b0
  };

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: assembles each 32-bit instruction from four byte reads
// on the shared 8-bit memory port and hands PC/instruction pairs to IF/ID.
module if_fetch
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [7:0]  mem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        stallreq_o
);

  fetch_regs_t r;
  fetch_regs_t r_nxt;
  logic        req;
  logic        outstanding;
  logic        stall_unused;

  assign stall_unused = ^stall[5:1];

  assign req = (r.state == FETCH_BUSY) && !r.waiting && !r.discard;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r <= FETCH_RESET;
    end else begin
      r <= r_nxt;
    end
  end

  always_comb begin
    r_nxt       = r;
    outstanding = 1'b0;
    unique case (r.state)
      FETCH_BUSY: begin
        if (req && mem_gnt_i) begin
          r_nxt.waiting = 1'b1;
        end
        if (mem_rvalid_i && r.discard) begin
          r_nxt.discard = 1'b0;
          r_nxt.waiting = 1'b0;
        end else if (mem_rvalid_i && r.waiting) begin
          r_nxt.inst_buf[{r.cnt, 3'b000} +: 8] = mem_rdata_i;
          r_nxt.waiting = 1'b0;
          r_nxt.cnt     = r.cnt + 2'd1;
          if (r.cnt == 2'd3) begin
            r_nxt.state = FETCH_READY;
          end
        end
        // A redirect overrides the byte bookkeeping above; a byte still in
        // flight after this edge must be swallowed before requesting again.
        if (branch_flag_i) begin
          outstanding   = (r.waiting && !mem_rvalid_i) || (req && mem_gnt_i);
          r_nxt.pc      = branch_target_i;
          r_nxt.cnt     = 2'd0;
          r_nxt.state   = FETCH_BUSY;
          r_nxt.waiting = outstanding;
          r_nxt.discard = outstanding;
        end
      end
      FETCH_READY: begin
        if (!stall[0]) begin
          r_nxt.pc    = branch_flag_i ? branch_target_i : r.pc + 32'd4;
          r_nxt.cnt   = 2'd0;
          r_nxt.state = FETCH_BUSY;
        end
      end
    endcase
  end

  assign mem_req_o  = req;
  assign mem_addr_o = r.pc + 32'(r.cnt);
  assign if_pc_o    = (r.state == FETCH_READY) ? r.pc : ZERO_WORD;
  assign if_inst_o  = (r.state == FETCH_READY) ? r.inst_buf : ZERO_WORD;
  assign stallreq_o = (r.state == FETCH_BUSY);

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: byte-wide memory responder plus a word-level model of
// which instruction should be presented at which PC.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq;

  int checks   = 0;
  int failures = 0;

  int          rv_delay  = 1;
  int          gnt_hold  = 0;
  bit          rand_mode = 1'b0;
  bit          pend      = 1'b0;
  int          pend_left = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] gnt_log[$];

  always #5 clk = ~clk;

  if_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_flag_i   (branch_flag),
    .branch_target_i (branch_target),
    .mem_req_o       (mem_req),
    .mem_addr_o      (mem_addr),
    .mem_gnt_i       (mem_gnt),
    .mem_rvalid_i    (mem_rvalid),
    .mem_rdata_i     (mem_rdata),
    .if_pc_o         (if_pc),
    .if_inst_o       (if_inst),
    .stallreq_o      (stallreq)
  );

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return (a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  // Memory: one request at a time, grant after gnt_hold cycles, data rv_delay later.
  initial begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (pend) begin
        if (pend_left <= 1) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_byte(pend_addr);
          pend       = 1'b0;
        end else begin
          pend_left--;
        end
      end
      if (!rst && mem_req && !pend) begin
        if (gnt_hold > 0) begin
          gnt_hold--;
        end else begin
          mem_gnt   = 1'b1;
          pend      = 1'b1;
          pend_left = rv_delay;
          pend_addr = mem_addr;
          gnt_log.push_back(mem_addr);
          if (rand_mode) begin
            gnt_hold = $urandom_range(0, 2);
            rv_delay = $urandom_range(1, 3);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int budget, output int cyc);
    cyc = 0;
    while (stallreq !== 1'b0 && cyc < budget) begin
      step();
      cyc++;
    end
    check("ready_reached", {31'd0, stallreq}, 32'd0);
  endtask

  initial begin
    int          cyc;
    int          nbr;
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    bit          br;

    stall         = 6'h01;
    branch_flag   = 1'b0;
    branch_target = '0;
    rst           = 1'b1;
    step();
    step();
    check("rst_req", {31'd0, mem_req}, 32'd1);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_inst", if_inst, 32'd0);
    check("rst_stallreq", {31'd0, stallreq}, 32'd1);

    rst = 1'b0;
    wait_ready(100, cyc);
    check("first_latency", cyc, 32'd8);
    check("first_pc", if_pc, 32'd0);
    check("first_inst", if_inst, 32'h00100513);

    // Held in READY; a branch pulse during the stall must be ignored.
    for (int i = 0; i < 5; i++) begin
      branch_flag   = (i == 2);
      branch_target = 32'h999;
      step();
      check("hold_stallreq", {31'd0, stallreq}, 32'd0);
      check("hold_req", {31'd0, mem_req}, 32'd0);
      check("hold_pc", if_pc, 32'd0);
      check("hold_inst", if_inst, 32'h00100513);
    end
    branch_flag = 1'b0;

    stall = 6'h00;
    step();
    stall = 6'h01;
    check("adv_stallreq", {31'd0, stallreq}, 32'd1);
    check("adv_req", {31'd0, mem_req}, 32'd1);
    check("adv_addr", mem_addr, 32'd4);
    wait_ready(100, cyc);
    check("adv_latency", cyc, 32'd8);
    check("adv_pc", if_pc, 32'd4);
    check("adv_inst", if_inst, mem_word(32'd4));

    stall         = 6'h00;
    branch_flag   = 1'b1;
    branch_target = 32'h40;
    step();
    stall       = 6'h01;
    branch_flag = 1'b0;
    check("rdybr_req", {31'd0, mem_req}, 32'd1);
    check("rdybr_addr", mem_addr, 32'h40);
    wait_ready(100, cyc);
    check("rdybr_pc", if_pc, 32'h40);
    check("rdybr_inst", if_inst, mem_word(32'h40));

    gnt_hold = 3;
    stall    = 6'h00;
    step();
    stall = 6'h01;
    for (int i = 0; i < 4; i++) begin
      check("gnt_wait_req", {31'd0, mem_req}, 32'd1);
      check("gnt_wait_addr", mem_addr, 32'h44);
      step();
    end
    wait_ready(100, cyc);
    check("gnt_wait_latency", cyc + 4, 32'd11);
    check("gnt_wait_inst", if_inst, mem_word(32'h44));

    // Redirect while byte 1 of the fetch at 0x48 is in flight.
    rv_delay = 2;
    stall    = 6'h00;
    step();
    stall = 6'h01;
    cyc   = 0;
    while (!(mem_req === 1'b1 && mem_addr === 32'h49) && cyc < 40) begin
      step();
      cyc++;
    end
    check("midbr_byte1_req", mem_addr, 32'h49);
    step();
    check("midbr_outstanding", {31'd0, mem_req}, 32'd0);
    gnt_log.delete();
    branch_flag   = 1'b1;
    branch_target = 32'h100;
    step();
    branch_flag = 1'b0;
    check("midbr_discarding", {31'd0, mem_req}, 32'd0);
    step();
    check("midbr_resume_req", {31'd0, mem_req}, 32'd1);
    check("midbr_resume_addr", mem_addr, 32'h100);
    wait_ready(100, cyc);
    check("midbr_pc", if_pc, 32'h100);
    check("midbr_inst", if_inst, mem_word(32'h100));
    check("midbr_gnt_count", gnt_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
      check("midbr_gnt_addr", gnt_log[i], 32'h100 + 32'(i));
    end

    // Reset with a slow reply still in flight.
    rv_delay = 4;
    stall    = 6'h00;
    step();
    stall = 6'h01;
    step();
    rst = 1'b1;
    step();
    gnt_log.delete();
    check("midrst_req", {31'd0, mem_req}, 32'd1);
    check("midrst_addr", mem_addr, 32'd0);
    check("midrst_stallreq", {31'd0, stallreq}, 32'd1);
    check("midrst_pc", if_pc, 32'd0);
    check("midrst_inst", if_inst, 32'd0);
    rst = 1'b0;
    wait_ready(100, cyc);
    check("midrst_ready_pc", if_pc, 32'd0);
    check("midrst_ready_inst", if_inst, 32'h00100513);
    check("midrst_gnt_count", gnt_log.size(), 32'd4);
    rv_delay = 1;

    rand_mode = 1'b1;
    exp_pc    = 32'd0;
    for (int n = 0; n < 40; n++) begin
      for (int h = 0; h < int'($urandom_range(0, 2)); h++) begin
        step();
      end
      br  = ($urandom_range(0, 3) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom;
      stall         = 6'($urandom) & 6'h3E;
      branch_flag   = br;
      branch_target = tgt;
      exp_pc        = br ? tgt : exp_pc + 32'd4;
      step();
      branch_flag = 1'b0;
      cyc = 0;
      nbr = 0;
      while (stallreq === 1'b1 && cyc < 300) begin
        stall = 6'($urandom);
        if (nbr < 2 && $urandom_range(0, 15) == 0) begin
          tgt           = $urandom;
          branch_flag   = 1'b1;
          branch_target = tgt;
          exp_pc        = tgt;
          nbr++;
        end
        step();
        branch_flag = 1'b0;
        cyc++;
      end
      stall = 6'($urandom) | 6'h01;
      check("rand_ready", {31'd0, stallreq}, 32'd0);
      check("rand_pc", if_pc, exp_pc);
      check("rand_inst", if_inst, mem_word(exp_pc));
    end
    rand_mode = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the 5-stage RISC-V pipeline, directly upstream of the IF/ID pipeline register. Holds the program counter and fetches each 32-bit instruction as four byte reads over the shared 8-bit memory port. Presents a completed PC/instruction pair to IF/ID. Requests a pipeline stall from the controller while a fetch is in progress, and accepts branch redirects from ID at any point in a fetch.

## Interface
Parameters:
- none; all widths come from the shared defines.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, synchronous, active-high (`RstEnable` = 1).
- stall  in  6  controller stall vector; bit 0 holds the PC/fetch stage.
- branch_flag_i  in  1  redirect request from ID, single-cycle pulse.
- branch_target_i  in  32  redirect PC; valid when branch_flag_i = 1.
- mem_req_o  out  1  byte read request.
- mem_addr_o  out  32  byte address; valid when mem_req_o = 1.
- mem_gnt_i  in  1  arbiter accepted the request this cycle.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  8  read data byte.
- if_pc_o  out  32  PC of the presented instruction.
- if_inst_o  out  32  presented instruction.
- stallreq_o  out  1  fetch incomplete; controller must stall IF/ID and earlier stages.

## Operation
- State: state ∈ {BUSY, READY}, pc[31:0], cnt[1:0] (next byte index), buf[31:0], waiting (one byte outstanding), discard (outstanding byte belongs to an abandoned fetch).
- Reset: state = BUSY, pc = 0, cnt = 0, buf = 0, waiting = 0, discard = 0.
- Reset values of outputs: mem_req_o = 1 (first request, address 0), if_pc_o = 0, if_inst_o = 0, stallreq_o = 1.
- mem_req_o = (state == BUSY) && !waiting && !discard.
- mem_addr_o = pc + cnt (32-bit add, wraps modulo 2^32).
- mem_req_o && mem_gnt_i → waiting = 1.
- mem_rvalid_i && waiting && !discard → buf[8*cnt+7 : 8*cnt] = mem_rdata_i (little-endian); waiting = 0; cnt++. If cnt was 3, state = READY.
- mem_rvalid_i && discard → drop the byte; clear discard and waiting.
- mem_rvalid_i while neither waiting nor discard is set (including a stale reply after reset) → ignore.
- READY: if_pc_o = pc, if_inst_o = buf, stallreq_o = 0, mem_req_o = 0.
- BUSY: if_pc_o = 0, if_inst_o = 0 (bubble), stallreq_o = 1.
- READY with stall[0] = 0: advance. pc = branch_flag_i ? branch_target_i : pc + 4; cnt = 0; state = BUSY.
- READY with stall[0] = 1: hold all state. branch_flag_i is ignored; ID re-asserts it after the stall clears.
- BUSY with branch_flag_i (honoured regardless of stall):
  - pc = branch_target_i, cnt = 0.
  - If a byte is outstanding (waiting, or gnt in this cycle), set discard.
  - New requests resume after discard clears.
- Targets are not alignment-checked; a misaligned target fetches bytes at target..target+3.

## Timing
- At most one memory request outstanding.
- A byte costs at least 2 cycles: request/gnt, then rvalid at the earliest on the next cycle.
- Zero-wait fetch: BUSY for 8 cycles, then READY. if_inst_o is valid in the cycle after the 4th rvalid.
- READY → BUSY on the same edge that IF/ID captures the instruction; the next fetch's first request is in the following cycle.
- Redirect during BUSY costs the remaining wait of any outstanding byte, plus a full 4-byte fetch.
- A gnt delay of N cycles extends BUSY by N cycles. mem_req_o and mem_addr_o are held stable until gnt.

## Structure
- Use `RstEnable`, `ZeroWord`, `InstAddrBus` and `InstBus` from defines.v.
- Add `FetchBusy` and `FetchReady` state encodings to defines.v.
- Single module; no sub-module needed.

## Test plan
- Reset, then zero-wait memory with bytes 13,05,10,00 at addresses 0..3:
  - READY at cycle 8 with if_inst_o = 0x00100513, if_pc_o = 0.
  - Next request address is 4.
- stall[0] held at 1 for 5 cycles while READY: outputs stay constant, mem_req_o = 0, PC does not advance.
- branch_flag_i with target 0x100 while byte 1 is outstanding:
  - The late byte is discarded.
  - The next request is 0x100, and the instruction presented comes from 0x100..0x103 with if_pc_o = 0x100.
- branch_flag_i with target 0x40 in READY with stall[0] = 0: the next fetch starts at 0x40, not pc + 4.
- mem_gnt_i withheld for 3 cycles: mem_addr_o is stable throughout and READY is delayed by exactly 3 cycles.
- rst asserted mid-fetch with a reply still in flight: state returns to reset values and the stale rvalid is ignored.
